mips_mem_responder: RTL and testbench



---
 rtl/mips_mem_pkg.sv | 31 +++
 rtl/mem_seg_decode.sv | 25 ++
 rtl/mips_mem_responder.sv | 117 +++++++++++
 tb/tb_mips_mem_responder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared constants, state encoding and byte-lane helper for the MIPS memory responder.
package mips_mem_pkg;

    localparam logic [31:0] DEF_TEXT_BASE  = 32'h0040_0000;
    localparam int unsigned DEF_TEXT_WORDS = 1024;
    localparam logic [31:0] DEF_DATA_BASE  = 32'h1000_0000;
    localparam int unsigned DEF_DATA_WORDS = 1024;

    localparam int unsigned LANES  = 4;
    localparam int unsigned LANE_W = 8;

    typedef enum logic [1:0] {
        MS_RUN,
        MS_DUMP,
        MS_DONE
    } mem_state_t;

    function automatic logic [LANES*LANE_W-1:0] lane_merge(
        input logic [LANES*LANE_W-1:0] old_word,
        input logic [LANES*LANE_W-1:0] new_word,
        input logic [LANES-1:0]        mask
    );
        logic [LANES*LANE_W-1:0] merged;
        merged = old_word;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (mask[i]) merged[i*LANE_W +: LANE_W] = new_word[i*LANE_W +: LANE_W];
        end
        return merged;
    endfunction

endpackage

// File: rtl/mem_seg_decode.sv
// Range decode of a byte address against one segment: hit flag and word index.
module mem_seg_decode #(
    parameter logic [31:0] BASE  = 32'h0000_0000,
    parameter int unsigned WORDS = 1024
) (
    input  logic [31:0]                i_byte_addr,
    output logic                       o_hit,
    output logic [$clog2(WORDS)-1:0]   o_idx
);

    // Limit is held in 33 bits so a segment ending at 4 GiB does not wrap.
    localparam logic [32:0] LIMIT = {1'b0, BASE} + (33'(WORDS) << 2);

    logic [31:0] w_off;

    always_comb begin
        w_off = i_byte_addr - BASE;
        o_hit = (i_byte_addr >= BASE) && ({1'b0, i_byte_addr} < LIMIT);
        o_idx = w_off[$clog2(WORDS)+1:2];
    end

    logic w_unused;
    assign w_unused = ^{w_off[31:$clog2(WORDS)+2], w_off[1:0]};

endmodule

// File: rtl/mips_mem_responder.sv
// Text/data memory responder for the single-cycle MIPS core, with a
// valid/ready dump of the data segment once the core halts.
module mips_mem_responder
    import mips_mem_pkg::*;
#(
    parameter logic [31:0] TEXT_BASE  = DEF_TEXT_BASE,
    parameter int unsigned TEXT_WORDS = DEF_TEXT_WORDS,
    parameter logic [31:0] DATA_BASE  = DEF_DATA_BASE,
    parameter int unsigned DATA_WORDS = DEF_DATA_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] inst_addr,
    output logic [31:0] inst,
    output logic        inst_excpt,
    input  logic [29:0] mem_addr,
    input  logic [31:0] mem_data_in,
    input  logic [3:0]  mem_write_en,
    output logic [31:0] mem_data_out,
    output logic        mem_excpt,
    input  logic        halted,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [31:0] dump_addr,
    output logic [31:0] dump_data,
    output logic        dump_done
);

    localparam int unsigned TW = $clog2(TEXT_WORDS);
    localparam int unsigned DW = $clog2(DATA_WORDS);
    localparam logic [DW-1:0] LAST_PTR = DW'(DATA_WORDS - 1);

    // Contents are preloaded by the simulation loader; text is never written here.
    logic [31:0] r_text [TEXT_WORDS];
    logic [31:0] r_data [DATA_WORDS];

    mem_state_t    r_state, w_state_nxt;
    logic [DW-1:0] r_ptr, w_ptr_nxt;

    logic          w_ft_hit, w_dt_hit, w_dd_hit, w_wr_en;
    logic [TW-1:0] w_ft_idx, w_dt_idx;
    logic [DW-1:0] w_dd_idx;

    mem_seg_decode #(.BASE(TEXT_BASE), .WORDS(TEXT_WORDS)) u_fetch_text (
        .i_byte_addr ({inst_addr, 2'b00}),
        .o_hit       (w_ft_hit),
        .o_idx       (w_ft_idx)
    );

    mem_seg_decode #(.BASE(TEXT_BASE), .WORDS(TEXT_WORDS)) u_data_text (
        .i_byte_addr ({mem_addr, 2'b00}),
        .o_hit       (w_dt_hit),
        .o_idx       (w_dt_idx)
    );

    mem_seg_decode #(.BASE(DATA_BASE), .WORDS(DATA_WORDS)) u_data_data (
        .i_byte_addr ({mem_addr, 2'b00}),
        .o_hit       (w_dd_hit),
        .o_idx       (w_dd_idx)
    );

    always_comb begin
        inst       = w_ft_hit ? r_text[w_ft_idx] : '0;
        inst_excpt = !w_ft_hit;

        mem_data_out = '0;
        if (w_dd_hit)      mem_data_out = r_data[w_dd_idx];
        else if (w_dt_hit) mem_data_out = r_text[w_dt_idx];

        mem_excpt = !(w_dd_hit || w_dt_hit) || (w_dt_hit && (mem_write_en != '0));
        w_wr_en   = (r_state == MS_RUN) && !mem_excpt && !halted && w_dd_hit
                    && (mem_write_en != '0);
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_data[w_dd_idx] <= lane_merge(r_data[w_dd_idx], mem_data_in, mem_write_en);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= MS_RUN;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        dump_valid  = 1'b0;
        dump_done   = 1'b0;
        dump_addr   = DATA_BASE + 32'({r_ptr, 2'b00});
        dump_data   = r_data[r_ptr];

        unique case (r_state)
            MS_RUN: begin
                if (halted) w_state_nxt = MS_DUMP;
            end
            MS_DUMP: begin
                dump_valid = 1'b1;
                if (dump_ready) begin
                    w_ptr_nxt = r_ptr + 1'b1;
                    if (r_ptr == LAST_PTR) w_state_nxt = MS_DONE;
                end
            end
            MS_DONE: begin
                dump_done = 1'b1;
            end
            default: w_state_nxt = MS_RUN;
        endcase
    end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed bench for mips_mem_responder: fetch/load/store decode plus a
// scoreboarded check of the data-segment dump handshake.
module tb_mips_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] inst_addr;
    logic [31:0] inst;
    logic        inst_excpt;
    logic [29:0] mem_addr;
    logic [31:0] mem_data_in;
    logic [3:0]  mem_write_en;
    logic [31:0] mem_data_out;
    logic        mem_excpt;
    logic        halted;
    logic        dump_valid;
    logic        dump_ready;
    logic [31:0] dump_addr;
    logic [31:0] dump_data;
    logic        dump_done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } dump_exp_t;

    dump_exp_t sb[$];

    always #5 clk = ~clk;

    mips_mem_responder #(
        .TEXT_BASE  (32'h0040_0000),
        .TEXT_WORDS (16),
        .DATA_BASE  (32'h1000_0000),
        .DATA_WORDS (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_addr    (inst_addr),
        .inst         (inst),
        .inst_excpt   (inst_excpt),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_write_en (mem_write_en),
        .mem_data_out (mem_data_out),
        .mem_excpt    (mem_excpt),
        .halted       (halted),
        .dump_valid   (dump_valid),
        .dump_ready   (dump_ready),
        .dump_addr    (dump_addr),
        .dump_data    (dump_data),
        .dump_done    (dump_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] byte_addr, input logic [31:0] d, input logic [3:0] m);
        mem_addr     = byte_addr[31:2];
        mem_data_in  = d;
        mem_write_en = m;
        tick();
        mem_write_en = 4'b0000;
        #1;
    endtask

    // Walk the dump with a per-cycle ready pattern, scoring every presented word.
    task automatic run_dump(input int ncyc, input logic [15:0] rdy_pat,
                            output int hs, output int done_cyc);
        hs = 0;
        done_cyc = 0;
        for (int c = 1; c <= ncyc; c++) begin
            dump_ready = rdy_pat[c-1];
            #1;
            if (dump_done && done_cyc == 0) done_cyc = c;
            if (dump_valid) begin
                if (sb.size() == 0) begin
                    chk("dump_unexpected_word", 32'(sb.size()), 32'd1);
                end else begin
                    chk("dump_addr", dump_addr, sb[0].addr);
                    chk("dump_data", dump_data, sb[0].data);
                    if (dump_ready) begin
                        void'(sb.pop_front());
                        hs++;
                    end
                end
            end
            tick();
        end
        dump_ready = 1'b0;
    endtask

    initial begin
        int hs;
        int done_cyc;

        rst          = 1'b1;
        inst_addr    = '0;
        mem_addr     = '0;
        mem_data_in  = '0;
        mem_write_en = '0;
        halted       = 1'b0;
        dump_ready   = 1'b0;
        for (int i = 0; i < 16; i++) dut.r_text[i] = 32'hC0DE_0000 + 32'(i);
        dut.r_text[0] = 32'h2402_000a;
        dut.r_text[2] = 32'hDEAD_BEEF;

        tick();
        tick();
        chk("rst_dump_valid", {31'b0, dump_valid}, 32'd0);
        chk("rst_dump_done",  {31'b0, dump_done},  32'd0);
        chk("rst_dump_addr",  dump_addr,           32'h1000_0000);
        rst = 1'b0;
        tick();

        // Fetch port: hit, miss below, last word, first word past the end.
        inst_addr = 30'h0010_0000; #1;
        chk("fetch_text0",      inst,                 32'h2402_000a);
        chk("fetch_text0_exc",  {31'b0, inst_excpt},  32'd0);
        inst_addr = 30'h0; #1;
        chk("fetch_zero",       inst,                 32'd0);
        chk("fetch_zero_exc",   {31'b0, inst_excpt},  32'd1);
        inst_addr = 30'h0010_000F; #1;
        chk("fetch_last",       inst,                 32'hC0DE_000F);
        chk("fetch_last_exc",   {31'b0, inst_excpt},  32'd0);
        inst_addr = 30'h0010_0010; #1;
        chk("fetch_past",       inst,                 32'd0);
        chk("fetch_past_exc",   {31'b0, inst_excpt},  32'd1);

        // Byte-lane store; same-cycle read returns the old word.
        store(32'h1000_0004, 32'h1122_3344, 4'b1111);
        chk("ld_word1",         mem_data_out,         32'h1122_3344);
        mem_addr     = 30'h0400_0001;
        mem_data_in  = 32'hAABB_CCDD;
        mem_write_en = 4'b0101;
        #1;
        chk("st_lane_old",      mem_data_out,         32'h1122_3344);
        chk("st_lane_exc",      {31'b0, mem_excpt},   32'd0);
        tick();
        mem_write_en = 4'b0000; #1;
        chk("st_lane_new",      mem_data_out,         32'h11BB_33DD);

        // Store into text is illegal and leaves the word intact.
        mem_addr     = 30'h0010_0002;
        mem_data_in  = 32'h0BAD_0BAD;
        mem_write_en = 4'b1111;
        #1;
        chk("st_text_exc",      {31'b0, mem_excpt},   32'd1);
        tick();
        mem_write_en = 4'b0000; #1;
        chk("ld_text_exc",      {31'b0, mem_excpt},   32'd0);
        chk("ld_text_keep",     mem_data_out,         32'hDEAD_BEEF);
        chk("fetch_text2",      dut.r_text[2],        32'hDEAD_BEEF);

        mem_addr = 30'h0800_0000; #1;
        chk("ld_unmapped",      mem_data_out,         32'd0);
        chk("ld_unmapped_exc",  {31'b0, mem_excpt},   32'd1);
        mem_addr = 30'h0400_0004; #1;
        chk("ld_data_past_exc", {31'b0, mem_excpt},   32'd1);

        store(32'h1000_0000, 32'd1, 4'b1111);
        store(32'h1000_0004, 32'd2, 4'b1111);
        store(32'h1000_0008, 32'd3, 4'b1111);
        store(32'h1000_000C, 32'd4, 4'b1111);

        // Halt with a simultaneous store: the store must be dropped.
        for (int i = 0; i < 4; i++) sb.push_back('{32'h1000_0000 + 32'(4*i), 32'(i + 1)});
        halted       = 1'b1;
        mem_addr     = 30'h0400_0000;
        mem_data_in  = 32'h0000_0099;
        mem_write_en = 4'b1111;
        tick();
        halted       = 1'b0;
        mem_write_en = 4'b0000;
        run_dump(8, 16'hFFFF, hs, done_cyc);
        chk("dump1_handshakes", 32'(hs),              32'd4);
        chk("dump1_done_cycle", 32'(done_cyc),        32'd5);
        chk("dump1_sb_empty",   32'(sb.size()),       32'd0);
        chk("dump1_done_stay",  {31'b0, dump_done},   32'd1);
        chk("dump1_valid_low",  {31'b0, dump_valid},  32'd0);

        // Restart, stall the dump, then reset partway through.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_dump_done",   {31'b0, dump_done},   32'd0);
        chk("rst2_dump_data",   dump_data,            32'd1);
        for (int i = 0; i < 4; i++) sb.push_back('{32'h1000_0000 + 32'(4*i), 32'(i + 1)});
        halted = 1'b1;
        tick();
        halted = 1'b0;
        run_dump(4, 16'b1001, hs, done_cyc);
        chk("dump2_handshakes", 32'(hs),              32'd2);
        chk("dump2_next_addr",  dump_addr,            32'h1000_0008);
        chk("dump2_next_data",  dump_data,            32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        chk("rst3_dump_valid",  {31'b0, dump_valid},  32'd0);
        chk("rst3_dump_done",   {31'b0, dump_done},   32'd0);
        chk("rst3_dump_addr",   dump_addr,            32'h1000_0000);
        tick();
        chk("run_dump_valid",   {31'b0, dump_valid},  32'd0);
        store(32'h1000_000C, 32'h0000_0055, 4'b0001);
        chk("run_store_ok",     mem_data_out,         32'h0000_0055);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

endmodule
